// File: rtl/exec_control_unit.sv
// Purpose: debounced run/stop and N-cycle step controller producing a core clock enable and stretched core reset.
// Latency: button press acts 1+DEBOUNCE_CYCLES edges after the raw level rises; outputs are registered state decodes.
// Backpressure: none; HALT is a level that forces IDLE on the next edge, and presses outside IDLE/RUN/STEP are dropped.
//
// Ports:
//   CLOCK, RESET (sync, active-low)        - clock and reset
//   EXEC, STEP                             - raw bouncy buttons (asynchronous)
//   STEP_COUNT                             - cycles per step press, latched when a STEP press is accepted
//   HALT                                   - core halt request, level
//   CLK_EN, RES_SIG, RUNNING, STEP_DONE    - core clock enable, core reset, busy flag, step-complete pulse
module exec_control_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_WIDTH      = 8,
    parameter int RES_STRETCH     = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  EXEC,
    input  logic                  STEP,
    input  logic [STEP_WIDTH-1:0] STEP_COUNT,
    input  logic                  HALT,
    output logic                  CLK_EN,
    output logic                  RES_SIG,
    output logic                  RUNNING,
    output logic                  STEP_DONE
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW = $clog2(RES_STRETCH + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RST_LOAD = RW'(RES_STRETCH);

    typedef enum logic [1:0] {
        S_RESETTING,
        S_IDLE,
        S_RUN,
        S_STEP
    } state_t;

    // Index 0 is EXEC, index 1 is STEP.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];

    logic exec_press;
    logic step_press;

    state_t                state;
    state_t                state_n;
    logic [RW-1:0]         rst_cnt;
    logic [RW-1:0]         rst_cnt_n;
    logic [STEP_WIDTH-1:0] step_cnt;
    logic [STEP_WIDTH-1:0] step_cnt_n;
    logic                  step_done;
    logic                  step_done_n;

    assign btn_raw = {STEP, EXEC};

    // Synchronizer and debouncer: the accepted level only follows the
    // synchronized input after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            sync1     <= '0;
            sync2     <= '0;
            db        <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // A press is the rising acceptance, visible on the same edge db goes high.
    always_comb begin
        press = '0;
        for (int i = 0; i < 2; i++) begin
            press[i] = sync2[i] & ~db[i] & (db_cnt[i] == DB_LAST);
        end
    end

    assign exec_press = press[0];
    assign step_press = press[1];

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state     <= S_RESETTING;
            rst_cnt   <= RST_LOAD;
            step_cnt  <= '0;
            step_done <= 1'b0;
        end else begin
            state     <= state_n;
            rst_cnt   <= rst_cnt_n;
            step_cnt  <= step_cnt_n;
            step_done <= step_done_n;
        end
    end

    always_comb begin
        state_n     = state;
        rst_cnt_n   = rst_cnt;
        step_cnt_n  = step_cnt;
        step_done_n = 1'b0;
        case (state)
            S_RESETTING: begin
                rst_cnt_n = rst_cnt - RW'(1);
                if (rst_cnt == RW'(1)) begin
                    state_n = S_IDLE;
                end
            end
            S_IDLE: begin
                if (exec_press && !HALT) begin
                    state_n = S_RUN;
                end else if (step_press && (STEP_COUNT != '0)) begin
                    state_n    = S_STEP;
                    step_cnt_n = STEP_COUNT;
                end
            end
            S_RUN: begin
                if (HALT || exec_press) begin
                    state_n = S_IDLE;
                end
            end
            S_STEP: begin
                // Abort wins over completion and suppresses STEP_DONE.
                if (HALT || exec_press) begin
                    state_n = S_IDLE;
                end else begin
                    step_cnt_n = step_cnt - STEP_WIDTH'(1);
                    if (step_cnt == STEP_WIDTH'(1)) begin
                        state_n     = S_IDLE;
                        step_done_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_RESETTING;
            end
        endcase
    end

    // Enable stays high while resetting so the core's synchronous reset is seen.
    assign CLK_EN    = (state != S_IDLE);
    assign RES_SIG   = (state == S_RESETTING);
    assign RUNNING   = (state == S_RUN) || (state == S_STEP);
    assign STEP_DONE = step_done;

endmodule

// File: tb/tb_exec_control_unit.sv
module tb_exec_control_unit;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       exec_b     = 1'b0;
    logic       step_b     = 1'b0;
    logic [7:0] step_count = 8'd0;
    logic       halt       = 1'b0;
    logic       clk_en;
    logic       res_sig;
    logic       running;
    logic       step_done;

    int errors = 0;
    int checks = 0;

    // Expected output nibbles {CLK_EN, RES_SIG, RUNNING, STEP_DONE}
    localparam logic [3:0] O_RST  = 4'b1100;
    localparam logic [3:0] O_IDLE = 4'b0000;
    localparam logic [3:0] O_BUSY = 4'b1010;
    localparam logic [3:0] O_DONE = 4'b0001;

    always #5 clk = ~clk;

    exec_control_unit #(
        .DEBOUNCE_CYCLES(4),
        .STEP_WIDTH     (8),
        .RES_STRETCH    (4)
    ) dut (
        .CLOCK     (clk),
        .RESET     (rst_n),
        .EXEC      (exec_b),
        .STEP      (step_b),
        .STEP_COUNT(step_count),
        .HALT      (halt),
        .CLK_EN    (clk_en),
        .RES_SIG   (res_sig),
        .RUNNING   (running),
        .STEP_DONE (step_done)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp);
        checks++;
        assert ({clk_en, res_sig, running, step_done} === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b required %b", tag,
                   {clk_en, res_sig, running, step_done}, exp);
        end
    endtask

    // Clean press: held long enough to be accepted, then a debounced release.
    task automatic press_btn(input bit use_step);
        if (use_step) step_b = 1'b1;
        else          exec_b = 1'b1;
        tick(6);
        exec_b = 1'b0;
        step_b = 1'b0;
        tick(6);
    endtask

    initial begin
        // Reset and stretch
        tick(3);
        check("reset_hold", O_RST);
        rst_n = 1'b1;
        tick(1);
        check("stretch_r0", O_RST);
        tick(2);
        check("stretch_r2", O_RST);
        tick(1);
        check("stretch_end", O_IDLE);

        // 2-cycle glitch is filtered
        exec_b = 1'b1;
        tick(2);
        exec_b = 1'b0;
        tick(10);
        check("glitch", O_IDLE);

        // EXEC start latency: transition at edge k+5
        exec_b = 1'b1;
        tick(5);
        check("run_k4", O_IDLE);
        tick(1);
        check("run_k5", O_BUSY);
        exec_b = 1'b0;
        tick(8);
        check("run_held", O_BUSY);
        exec_b = 1'b1;
        tick(5);
        check("stop_k4", O_BUSY);
        tick(1);
        check("stop_k5", O_IDLE);
        exec_b = 1'b0;
        tick(8);

        // STEP N=3: enable for exactly 3 cycles, then one STEP_DONE
        step_count = 8'd3;
        step_b = 1'b1;
        tick(5);
        check("step_k4", O_IDLE);
        tick(1);
        check("step_c1", O_BUSY);
        step_b = 1'b0;
        tick(2);
        check("step_c3", O_BUSY);
        tick(1);
        check("step_done", O_DONE);
        tick(1);
        check("step_done_clr", O_IDLE);
        tick(6);

        // STEP_COUNT=0 is ignored
        step_count = 8'd0;
        step_b = 1'b1;
        tick(6);
        check("step_zero", O_IDLE);
        step_b = 1'b0;
        tick(6);
        check("step_zero_after", O_IDLE);

        // HALT during RUN, then EXEC while halted
        press_btn(1'b0);
        check("halt_pre_run", O_BUSY);
        halt = 1'b1;
        tick(1);
        check("halt_run", O_IDLE);
        press_btn(1'b0);
        check("exec_while_halt", O_IDLE);
        halt = 1'b0;
        tick(1);
        check("halt_released", O_IDLE);

        // HALT during STEP N=10 at the fourth enabled cycle
        step_count = 8'd10;
        step_b = 1'b1;
        tick(6);
        check("hstep_c1", O_BUSY);
        step_b = 1'b0;
        tick(3);
        check("hstep_c4", O_BUSY);
        halt = 1'b1;
        tick(1);
        check("hstep_abort", O_IDLE);
        halt = 1'b0;
        tick(10);
        check("hstep_no_done", O_IDLE);

        // Simultaneous EXEC and STEP acceptance: RUN wins
        step_count = 8'd10;
        exec_b = 1'b1;
        step_b = 1'b1;
        tick(6);
        check("prio_start", O_BUSY);
        exec_b = 1'b0;
        step_b = 1'b0;
        tick(14);
        check("prio_is_run", O_BUSY);
        press_btn(1'b0);
        check("prio_stop", O_IDLE);

        // EXEC press aborts a STEP
        step_b = 1'b1;
        tick(6);
        check("estep_c1", O_BUSY);
        step_b = 1'b0;
        tick(2);
        exec_b = 1'b1;
        tick(6);
        check("estep_abort", O_IDLE);
        exec_b = 1'b0;
        tick(6);
        check("estep_no_done", O_IDLE);

        // Reset mid-STEP discards the step
        step_b = 1'b1;
        tick(6);
        check("rstep_c1", O_BUSY);
        step_b = 1'b0;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("rstep_reset", O_RST);
        rst_n = 1'b1;
        tick(3);
        check("rstep_r2", O_RST);
        tick(1);
        check("rstep_r3", O_IDLE);
        tick(12);
        check("rstep_discarded", O_IDLE);

        // Maximum step count 255, no wrap
        step_count = 8'hFF;
        step_b = 1'b1;
        tick(6);
        check("max_c1", O_BUSY);
        step_b = 1'b0;
        tick(254);
        check("max_c255", O_BUSY);
        tick(1);
        check("max_done", O_DONE);
        tick(1);
        check("max_idle", O_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_control_unit.md
# exec_control_unit

Parametrised execution controller sitting between the board buttons and the processor core. Debounces raw RUN/STOP (EXEC) and single-step (STEP) buttons, runs a run/stop/N-step state machine, and drives a synchronous clock enable (CLK_EN, no gated clock) plus a stretched core reset (RES_SIG). It replaces the toggle-only control unit and adds debounce, multi-cycle stepping, core HALT handling and reset stretching.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a button level change (≥1)
- STEP_WIDTH, 8, width of the step-count input and internal step counter
- RES_STRETCH, 4, cycles RES_SIG stays high after RESET releases (≥1)

- CLOCK  in  1  system clock. All logic is on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- EXEC  in  1  raw RUN/STOP button, asynchronous, bouncy
- STEP  in  1  raw single-step button, asynchronous, bouncy
- STEP_COUNT  in  STEP_WIDTH  core cycles per step press, sampled on acceptance of a STEP press
- HALT  in  1  core halt request, level, synchronous to CLOCK
- CLK_EN  out  1  core clock enable
- RES_SIG  out  1  active-high core reset
- RUNNING  out  1  high in RUN or STEP
- STEP_DONE  out  1  one-cycle pulse when a step sequence completes normally

## Operation
- Per button: 2-flop synchronizer (s1<=raw, s2<=s1), then debouncer with level db and counter cnt.
  - If s2!=db: cnt increments. When cnt==DEBOUNCE_CYCLES-1, db<=s2 and cnt<=0.
  - If s2==db: cnt<=0.
  - press = s2 & ~db & (cnt==DEBOUNCE_CYCLES-1), combinational. It is consumed by the FSM on the same edge db rises.
  - Pulses shorter than DEBOUNCE_CYCLES samples are filtered. Releases are debounced identically but produce no event.
- FSM states: RESETTING, IDLE, RUN, STEP.
  - RESETTING:
    - While RESET=0: stay, rst_cnt<=RES_STRETCH.
    - Once RESET=1: rst_cnt decrements, and the FSM goes to IDLE on the edge where rst_cnt==1.
    - Presses are ignored.
  - IDLE:
    - exec_press & ~HALT -> RUN.
    - Else step_press & STEP_COUNT!=0 -> STEP, step_cnt<=STEP_COUNT.
    - step_press with STEP_COUNT==0 is ignored.
    - exec_press has priority over a simultaneous step_press.
  - RUN: HALT -> IDLE (priority). Else exec_press -> IDLE. step_press is ignored.
  - STEP:
    - HALT or exec_press -> IDLE (abort, no STEP_DONE).
    - Else step_cnt decrements. On the edge where step_cnt==1, -> IDLE with STEP_DONE<=1.
    - step_press is ignored.
- Outputs are Moore decodes of the state register, except STEP_DONE, which is a register.
  - CLK_EN=1 in RUN, STEP and RESETTING; 0 in IDLE. CLK_EN is forced high during reset so the core's synchronous reset takes effect.
  - RES_SIG=1 only in RESETTING.
  - RUNNING=1 in RUN or STEP.
  - STEP_DONE=1 for exactly one cycle following a normal STEP completion.

## Timing
- Reset (RESET=0 at an edge) gives: state=RESETTING, RES_SIG=1, CLK_EN=1, RUNNING=0, STEP_DONE=0, all sync/db/cnt registers 0.
- Reset is honoured in any state, including mid-step and mid-debounce. A pending step is discarded and db returns to 0.
- Reset release: RESET=1 first sampled at edge r. RES_SIG falls after edge r+RES_STRETCH-1, i.e. it is high for RES_STRETCH cycles after release.
- Button latency: raw level high from before edge k and held.
  - s2=1 after edge k+1.
  - db rises and the FSM transitions at edge k+1+DEBOUNCE_CYCLES.
  - CLK_EN changes in the following cycle.
- STEP with STEP_COUNT=N: CLK_EN is high for exactly N cycles. STEP_DONE is high in the first IDLE cycle.
- step_cnt is STEP_WIDTH bits. The maximum step is 2^STEP_WIDTH-1, with no wrap.
- A held button generates one press only. A new press needs a debounced release first.
- HALT is sampled every cycle and stops CLK_EN in the cycle after it is seen.

## Test plan
- Reset and stretch (RES_STRETCH=4): hold RESET=0 for 3 cycles, then release at edge r.
  - RES_SIG=1 and CLK_EN=1 through edge r+3, then RES_SIG=0, CLK_EN=0, RUNNING=0.
- Debounce (DEBOUNCE_CYCLES=4): 2-cycle EXEC glitch -> no state change.
- EXEC run/stop: EXEC held from edge k -> CLK_EN=1 after edge k+5. Second clean press -> CLK_EN=0 with the same latency.
- Step: STEP_COUNT=3, one STEP press -> CLK_EN high exactly 3 cycles, then a single STEP_DONE pulse.
  - STEP_COUNT=0 press -> no activity.
- HALT:
  - HALT=1 during RUN -> IDLE next edge, CLK_EN=0.
  - EXEC press while HALT=1 -> stays IDLE.
  - HALT during STEP N=10 at cycle 4 -> IDLE, no STEP_DONE.
- Priority and abort:
  - EXEC and STEP accepted on the same edge in IDLE -> RUN.
  - EXEC press mid-STEP -> IDLE, no STEP_DONE.
  - RESET=0 mid-STEP -> RESETTING, step discarded.
